tatzel_spi_cfg: RTL and testbench
=================================

# tatzel_spi_cfg

SPI target (mode 0) that lets an off-chip host initiator write and read an 8×8-bit configuration register file over the tile's dedicated digital pins. The register contents drive the trim, enable and bias-select bits of the tile's analog blocks. The block sits inside `tt_um_tatzeltapeout`:
- `ui_in` carries SCLK, CS_N and MOSI.
- `uo_out` carries MISO.
- The `cfg` bus feeds the analog macros.

All SPI pins are asynchronous to `clk` and are oversampled.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer flops on `sclk`, `cs_n` and `mosi` (≥2).
- `ID_VALUE`, 8'hA5: constant returned by register 7.

Ports:
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `sclk` input 1: SPI clock from the host, asynchronous. Maximum frequency is clk/4.
- `cs_n` input 1: SPI chip select, active-low, asynchronous.
- `mosi` input 1: host-to-target data, MSB first.
- `miso` output 1: target-to-host data.
- `miso_oe` output 1: high while the synchronized `cs_n` is low.
- `cfg` output 64: register file, flattened. Register k is `cfg[8k+7:8k]`.
- `wr_strobe` output 1: one-cycle pulse on each committed write.
- `wr_addr` output 3: address of the last committed write. Holds between writes.
- `frame_err` output 1: one-cycle pulse when a frame ends with an illegal bit count.

## Operation
Frame format is 16 bits, MSB first:
- Bit 15: R/W (1 = write, 0 = read).
- Bits 14:12: address.
- Bits 11:8: reserved, ignored.
- Bits 7:0: data. For a read, MOSI data is don't-care.

Input synchronization and edge detection:
- `sclk`, `cs_n` and `mosi` each pass through a `SYNC_STAGES`-flop synchronizer.
- One further register provides edge detection. The events are `sclk_rise`, `sclk_fall`, `cs_fall` and `cs_rise`.

Frame behaviour:
- **`cs_fall`:** clears the bit counter (5 bits, saturating at 17) and the input shift register.
- **`sclk_rise` with `cs_n` low:** shifts `mosi` into the shift register and increments the counter.
- **`sclk` edges with `cs_n` high:** ignored.
- **Read, load:** on the `sclk_rise` that brings the count to 8, if R/W = 0, the output shift register is loaded with `reg[addr]`.
- **Read, shift:** on each following `sclk_fall`, `miso` presents the next bit, MSB first. The first bit appears at the fall after the 8th rise.
- **`miso` outside the read data phase:** 0 at all other times, including during writes.
- **`cs_rise` with count = 16:** completes the frame.
  - Write to an address other than 7: `reg[addr]` takes the data, `wr_addr` takes the address, and `wr_strobe` pulses.
  - Read: no state change.
- **`cs_rise` with count ≠ 16 and ≠ 0:** `frame_err` pulses. There is no write and no strobe.
- **`cs_rise` with count = 0:** silent. No error and no write.
- **Register 7:** read-only. It always reads `ID_VALUE`, and `cfg[63:56]` = `ID_VALUE`. A write to it is discarded with no `wr_strobe` and no error.
- **`cs_fall` mid-frame** (glitch or restart): the frame is discarded. Counter and shift registers are cleared. No error is flagged, because no `cs_rise` was seen.

Reset values:
- `cfg[55:0]` = 0.
- `cfg[63:56]` = `ID_VALUE`.
- `miso`, `miso_oe`, `wr_strobe`, `frame_err` = 0.
- `wr_addr` = 0.
- Counter and shift registers = 0.
- The synchronizer and edge-detect flops reset to the idle level: `sclk` = 0, `cs_n` = 1. No spurious edge is therefore detected after reset.

Reset mid-frame aborts the frame with no write and no `frame_err`. The host must restart with a fresh `cs_n` falling edge.

## Timing
- **Pin-to-event latency:** `SYNC_STAGES`+1 `clk` cycles from a pin transition to its edge event.
- **Write commit:** `wr_strobe`, the `cfg` update and the `wr_addr` update all occur in the cycle after `cs_rise` is detected. With the default parameter this is 4 `clk` cycles after the `cs_n` pin rises. `cfg` holds the new value from the strobe cycle onward.
- **`frame_err`:** occurs in the same cycle position as `wr_strobe` would.
- **MISO turnaround:** `miso` changes `SYNC_STAGES`+2 cycles after a `sclk` pin fall.
  - Because `sclk` is at most clk/4, the bit is stable before the next host sampling rise.
  - The host holds `sclk` high and low for at least 2 `clk` periods each.
- **Back-to-back frames:** `cs_n` must stay high for at least 3 `clk` periods between frames. Two writes separated by this gap each produce their own strobe.
- **`miso_oe`:** follows the synchronized `cs_n`, with `SYNC_STAGES` cycles of latency.

## Test plan
- **Write register 3:** write addr 3 with data 0x5A (frame 0xB05A). Require a single `wr_strobe` pulse, `wr_addr` = 3, `cfg[31:24]` = 0x5A, and all other bytes unchanged.
- **Read register 3 back:** send read frame 0x3000. Require MISO bits 8–15 to equal 0x5A, `miso` = 0 during bits 0–7, `miso_oe` high only while `cs_n` is low, and no `wr_strobe`.
- **Register 7 protection:** read addr 7 and require 0xA5. Write 0xF0F0 (addr 7, data 0xF0) and require no `wr_strobe`, no `frame_err`, and `cfg[63:56]` still 0xA5.
- **Short and long frames:** send a 12-bit frame, then an 18-bit frame, each starting with write addr 1 and data 0xFF. Require one `frame_err` pulse per frame, no `wr_strobe`, and `cfg[15:8]` still 0.
- **Reset mid-frame:** assert `rst` for 1 cycle after 10 `sclk` rises of a write to addr 2, then complete the frame. Require no write and no error, and all outputs at their reset values. A following clean write to addr 2 with data 0x11 succeeds.
- **Ignored activity and back-to-back writes:** toggle `sclk` 20 times with `cs_n` high and require no events. Then send back-to-back writes to addr 0 (0x01) and addr 5 (0x22) with a 3-`clk` gap. Require two strobes, `cfg[7:0]` = 0x01 and `cfg[47:40]` = 0x22.

Source files
------------

// File: rtl/tatzel_spi_cfg.sv
// rtl/tatzel_spi_cfg.sv - SPI mode-0 target for the 8x8 analog configuration register file
`timescale 1ns/1ps
module tatzel_spi_cfg #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic [63:0] cfg,
  output logic        wr_strobe,
  output logic [2:0]  wr_addr,
  output logic        frame_err
);

  // synchronizer chains, oldest sample at the top bit
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  logic w_sclk_s;
  logic w_cs_s;
  logic w_mosi_s;

  // edge-detect stage: delayed levels plus registered events
  logic r_sclk_q;
  logic r_cs_q;
  logic r_mosi_q;
  logic r_sclk_rise;
  logic r_sclk_fall;
  logic r_cs_fall;
  logic r_cs_rise;

  // post-reset arming: frames are honoured only after cs_n is seen truly high
  logic [SYNC_STAGES:0] r_fill;
  logic                 r_armed;

  // frame state
  logic [4:0]  r_cnt;
  logic [15:0] r_shift;
  logic [7:0]  r_out_sh;
  logic        r_rd_active;
  logic [7:0]  r_regs [0:7];
  logic        r_miso;
  logic        r_strobe;
  logic        r_err;
  logic [2:0]  r_wr_addr;

  logic [15:0] w_shift_nxt;
  logic [2:0]  w_rd_addr;
  logic [7:0]  w_rd_byte;
  logic [2:0]  w_frame_addr;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  // address is known once 7 bits have arrived: R/W in bit 6, address in bits 5:3
  assign w_shift_nxt  = {r_shift[14:0], r_mosi_q};
  assign w_rd_addr    = r_shift[5:3];
  assign w_rd_byte    = (w_rd_addr == 3'd7) ? ID_VALUE : r_regs[w_rd_addr];
  assign w_frame_addr = r_shift[14:12];

  assign miso      = r_miso;
  assign miso_oe   = ~w_cs_s;
  assign wr_strobe = r_strobe;
  assign wr_addr   = r_wr_addr;
  assign frame_err = r_err;

  // bring the asynchronous pins into the clk domain, resetting to the idle bus levels
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  // register the synchronized levels and the edge events derived from them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_q    <= 1'b0;
      r_cs_q      <= 1'b1;
      r_mosi_q    <= 1'b0;
      r_sclk_rise <= 1'b0;
      r_sclk_fall <= 1'b0;
      r_cs_fall   <= 1'b0;
      r_cs_rise   <= 1'b0;
    end else begin
      r_sclk_q    <= w_sclk_s;
      r_cs_q      <= w_cs_s;
      r_mosi_q    <= w_mosi_s;
      r_sclk_rise <= w_sclk_s & ~r_sclk_q;
      r_sclk_fall <= ~w_sclk_s & r_sclk_q;
      r_cs_fall   <= ~w_cs_s & r_cs_q;
      r_cs_rise   <= w_cs_s & ~r_cs_q;
    end
  end

  // arm once the pipeline holds real pin samples and cs_n is high, so a reset taken
  // mid-frame cannot turn the tail of that frame into a write or an error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
      if (r_fill[SYNC_STAGES] && r_cs_q) begin
        r_armed <= 1'b1;
      end
    end
  end

  // frame engine: bit counting, read data shifting and write commit on cs rise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_out_sh    <= '0;
      r_rd_active <= 1'b0;
      r_miso      <= 1'b0;
      r_strobe    <= 1'b0;
      r_err       <= 1'b0;
      r_wr_addr   <= '0;
      for (int k = 0; k < 8; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      r_strobe <= 1'b0;
      r_err    <= 1'b0;
      if (r_armed) begin
        if (r_cs_fall) begin
          r_cnt       <= '0;
          r_shift     <= '0;
          r_rd_active <= 1'b0;
          r_miso      <= 1'b0;
        end else if (r_cs_rise) begin
          r_miso      <= 1'b0;
          r_rd_active <= 1'b0;
          if (r_cnt == 5'd16) begin
            if (r_shift[15] && (w_frame_addr != 3'd7)) begin
              r_regs[w_frame_addr] <= r_shift[7:0];
              r_wr_addr            <= w_frame_addr;
              r_strobe             <= 1'b1;
            end
          end else if (r_cnt != 5'd0) begin
            r_err <= 1'b1;
          end
        end else if (!r_cs_q) begin
          if (r_sclk_rise) begin
            r_shift <= w_shift_nxt;
            if (r_cnt != 5'd17) begin
              r_cnt <= r_cnt + 5'd1;
            end
            if ((r_cnt == 5'd7) && !r_shift[6]) begin
              r_out_sh    <= w_rd_byte;
              r_rd_active <= 1'b1;
            end
          end else if (r_sclk_fall) begin
            if (r_rd_active && (r_cnt >= 5'd8) && (r_cnt <= 5'd15)) begin
              r_miso   <= r_out_sh[7];
              r_out_sh <= {r_out_sh[6:0], 1'b0};
            end else begin
              r_miso <= 1'b0;
            end
          end
        end
      end
    end
  end

  // flatten the register file; the top byte is the fixed identification value
  always_comb begin
    cfg = '0;
    for (int k = 0; k < 7; k++) begin
      cfg[8*k +: 8] = r_regs[k];
    end
    cfg[63:56] = ID_VALUE;
  end

endmodule

// File: tb/tb_tatzel_spi_cfg.sv
// tb/tb_tatzel_spi_cfg.sv - self-checking bench for tatzel_spi_cfg
`timescale 1ns/1ps
module tb_tatzel_spi_cfg;

  localparam int HI = 4;
  localparam int LO = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk_p = 1'b0;
  logic        cs_p = 1'b1;
  logic        mosi_p = 1'b0;
  logic        miso;
  logic        miso_oe;
  logic [63:0] cfg;
  logic        wr_strobe;
  logic [2:0]  wr_addr;
  logic        frame_err;

  always #5 clk = ~clk;

  tatzel_spi_cfg #(.SYNC_STAGES(2), .ID_VALUE(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk_p),
    .cs_n      (cs_p),
    .mosi      (mosi_p),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .cfg       (cfg),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .frame_err (frame_err)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_strobe = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  logic [63:0] exp_cfg = {8'hA5, 56'h0};
  logic [2:0]  exp_wr_addr = 3'd0;
  logic        exp_strobe = 1'b0;
  logic        exp_err = 1'b0;
  logic        exp_miso = 1'b0;
  logic        exp_oe = 1'b0;

  logic [7:0]  m_regs [0:6];
  bit          m_armed = 1'b1;
  int          m_n = 0;
  logic [15:0] m_word = '0;
  bit          m_rd = 1'b0;
  logic [7:0]  m_rd_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  function automatic logic [63:0] m_cfg();
    logic [63:0] v;
    v = {8'hA5, 56'h0};
    for (int k = 0; k < 7; k++) v[8*k +: 8] = m_regs[k];
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("cfg", cfg, exp_cfg);
      check("wr_addr", 64'(wr_addr), 64'(exp_wr_addr));
      check("wr_strobe", 64'(wr_strobe), 64'(exp_strobe));
      check("frame_err", 64'(frame_err), 64'(exp_err));
      check("miso", 64'(miso), 64'(exp_miso));
      check("miso_oe", 64'(miso_oe), 64'(exp_oe));
      if (wr_strobe === 1'b1) n_strobe++;
      if (frame_err === 1'b1) n_err++;
    end
  end

  task automatic sched_oe(input logic v);
    fork
      begin
        repeat (2) @(posedge clk);
        exp_oe = v;
      end
    join_none
  endtask

  task automatic sched_miso(input logic v);
    fork
      begin
        repeat (4) @(posedge clk);
        exp_miso = v;
      end
    join_none
  endtask

  task automatic sched_write(input logic [63:0] v, input logic [2:0] a);
    fork
      begin
        repeat (4) @(posedge clk);
        exp_cfg = v;
        exp_wr_addr = a;
        exp_strobe = 1'b1;
        @(posedge clk);
        exp_strobe = 1'b0;
      end
    join_none
  endtask

  task automatic sched_err();
    fork
      begin
        repeat (4) @(posedge clk);
        exp_err = 1'b1;
        @(posedge clk);
        exp_err = 1'b0;
      end
    join_none
  endtask

  task automatic cs_low();
    cs_p = 1'b0;
    sched_oe(1'b1);
    if (m_armed) begin
      m_n = 0;
      m_word = '0;
      m_rd = 1'b0;
    end
  endtask

  task automatic cs_high();
    logic [2:0] a;
    cs_p = 1'b1;
    sched_oe(1'b0);
    if (m_armed) begin
      a = m_word[14:12];
      if (m_n == 16) begin
        if (m_word[15] && a != 3'd7) begin
          m_regs[a] = m_word[7:0];
          sched_write(m_cfg(), a);
        end
      end else if (m_n != 0) begin
        sched_err();
      end
      m_rd = 1'b0;
      sched_miso(1'b0);
    end else begin
      m_armed = 1'b1;
    end
  endtask

  task automatic sclk_bit(input logic b, output logic s);
    logic v;
    s = miso;
    mosi_p = b;
    sclk_p = 1'b1;
    if (!cs_p && m_armed) begin
      m_word = {m_word[14:0], b};
      if (m_n < 17) m_n++;
      if (m_n == 8 && !m_word[7]) begin
        m_rd = 1'b1;
        m_rd_data = (m_word[6:4] == 3'd7) ? 8'hA5 : m_regs[m_word[6:4]];
      end
    end
    repeat (HI) @(negedge clk);
    sclk_p = 1'b0;
    if (!cs_p && m_armed) begin
      v = (m_rd && m_n >= 8 && m_n <= 15) ? m_rd_data[15 - m_n] : 1'b0;
      sched_miso(v);
    end
    repeat (LO) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] w, input int nbits, input int gap, output logic [15:0] rx);
    logic b;
    logic s;
    cs_low();
    repeat (4) @(negedge clk);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      b = (i < 16) ? w[15 - i] : 1'b0;
      sclk_bit(b, s);
      if (i < 16) rx = {rx[14:0], s};
    end
    cs_high();
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_armed = cs_p;
    m_n = 0;
    m_word = '0;
    m_rd = 1'b0;
    for (int k = 0; k < 7; k++) m_regs[k] = '0;
    fork
      begin
        @(posedge clk);
        exp_cfg = {8'hA5, 56'h0};
        exp_wr_addr = 3'd0;
        exp_miso = 1'b0;
        exp_oe = 1'b0;
        exp_strobe = 1'b0;
        exp_err = 1'b0;
        repeat (2) @(posedge clk);
        exp_oe = ~cs_p;
      end
    join_none
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] rx;
    logic        s;
    logic [15:0] part;
    int          s0;
    int          e0;

    for (int k = 0; k < 7; k++) m_regs[k] = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk_on = 1'b1;

    check("reset_cfg", cfg, 64'hA500_0000_0000_0000);
    check("reset_wr_addr", 64'(wr_addr), 64'd0);
    check("reset_miso_oe", 64'(miso_oe), 64'd0);

    s0 = n_strobe; e0 = n_err;
    send_frame(16'hB05A, 16, 10, rx);
    check("wr3_strobes", 64'(n_strobe - s0), 64'd1);
    check("wr3_wr_addr", 64'(wr_addr), 64'd3);
    check("wr3_cfg", cfg, 64'hA500_0000_5A00_0000);

    s0 = n_strobe;
    send_frame(16'h3000, 16, 10, rx);
    check("rd3_data", 64'(rx[7:0]), 64'h5A);
    check("rd3_lead_zero", 64'(rx[15:8]), 64'h00);
    check("rd3_no_strobe", 64'(n_strobe - s0), 64'd0);
    check("rd3_oe_idle", 64'(miso_oe), 64'd0);

    send_frame(16'h7000, 16, 10, rx);
    check("rd7_data", 64'(rx[7:0]), 64'hA5);
    s0 = n_strobe; e0 = n_err;
    send_frame(16'hF0F0, 16, 10, rx);
    check("wr7_no_strobe", 64'(n_strobe - s0), 64'd0);
    check("wr7_no_err", 64'(n_err - e0), 64'd0);
    check("wr7_id", 64'(cfg[63:56]), 64'hA5);

    s0 = n_strobe; e0 = n_err;
    send_frame(16'h91FF, 12, 10, rx);
    check("short_err", 64'(n_err - e0), 64'd1);
    e0 = n_err;
    send_frame(16'h91FF, 18, 10, rx);
    check("long_err", 64'(n_err - e0), 64'd1);
    check("badlen_no_strobe", 64'(n_strobe - s0), 64'd0);
    check("badlen_reg1", 64'(cfg[15:8]), 64'h00);

    s0 = n_strobe; e0 = n_err;
    part = 16'hA0FF;
    cs_low();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) sclk_bit(part[15 - i], s);
    repeat (3) @(negedge clk);
    do_reset();
    for (int i = 10; i < 16; i++) sclk_bit(part[15 - i], s);
    cs_high();
    repeat (10) @(negedge clk);
    check("rstmid_no_strobe", 64'(n_strobe - s0), 64'd0);
    check("rstmid_no_err", 64'(n_err - e0), 64'd0);
    check("rstmid_cfg", cfg, 64'hA500_0000_0000_0000);
    check("rstmid_wr_addr", 64'(wr_addr), 64'd0);
    check("rstmid_miso", 64'(miso), 64'd0);
    check("rstmid_miso_oe", 64'(miso_oe), 64'd0);
    send_frame(16'hA011, 16, 10, rx);
    check("rstmid_wr2_cfg", cfg, 64'hA500_0000_0011_0000);
    check("rstmid_wr2_addr", 64'(wr_addr), 64'd2);

    s0 = n_strobe; e0 = n_err;
    for (int i = 0; i < 20; i++) sclk_bit(1'b1, s);
    check("idle_no_strobe", 64'(n_strobe - s0), 64'd0);
    check("idle_no_err", 64'(n_err - e0), 64'd0);
    send_frame(16'h8001, 16, 3, rx);
    send_frame(16'hD022, 16, 10, rx);
    check("b2b_strobes", 64'(n_strobe - s0), 64'd2);
    check("b2b_reg0", 64'(cfg[7:0]), 64'h01);
    check("b2b_reg5", 64'(cfg[47:40]), 64'h22);
    check("b2b_wr_addr", 64'(wr_addr), 64'd5);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
